// File: rtl/graydec_pkg.sv
// Shared types and elaboration helpers for the Gray-to-binary decoder.
//   state_e      : decoder FSM state
//   slice_count  : number of BPC-bit slices in a WIDTH-bit word
//   bpc_legal    : configuration check, BPC must evenly divide WIDTH
package graydec_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    function automatic int unsigned slice_count(input int unsigned width,
                                                input int unsigned bpc);
        return width / bpc;
    endfunction

    function automatic bit bpc_legal(input int unsigned width, input int unsigned bpc);
        return (bpc != 0) && ((width % bpc) == 0);
    endfunction

endpackage

// File: rtl/graydec_slice.sv
// Combinational BPC-bit Gray-to-binary stage.
//   cin  : previously resolved binary bit (the bit just above this slice)
//   g    : Gray-coded slice, MSB first
//   b    : resolved binary bits for this slice
//   cout : lowest resolved bit, feeds the next slice down
module graydec_slice
    import graydec_pkg::*;
#(
    parameter int unsigned BPC = 1
) (
    input  logic           cin,
    input  logic [BPC-1:0] g,
    output logic [BPC-1:0] b,
    output logic           cout
);

    always_comb begin
        logic prev;
        prev = cin;
        b    = '0;
        for (int i = int'(BPC) - 1; i >= 0; i--) begin
            b[i] = prev ^ g[i];
            prev = b[i];
        end
        cout = prev;
    end

endmodule

// File: rtl/graydec_seq.sv
// Multicycle Gray-to-binary decoder, resolves BPC bits per cycle MSB-first.
//   clk, reset            : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     : operand handshake (accepted only in IDLE)
//   gray                  : Gray-coded operand, sampled on the accept edge only
//   clear                 : synchronous abort to IDLE, beats every handshake
//   out_valid/out_ready   : result handshake
//   bin                   : decoded word (meaningful while out_valid is high)
//   busy                  : high while running or holding a result
module graydec_seq
    import graydec_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BPC   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gray,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin,
    output logic             busy
);

    localparam int unsigned NSlices = slice_count(WIDTH, BPC);
    localparam int unsigned CntW    = (NSlices > 1) ? $clog2(NSlices) : 1;

    if (!bpc_legal(WIDTH, BPC)) begin : g_cfg_check
        $error("graydec_seq: WIDTH must be a non-zero multiple of BPC");
    end

    state_e                         state_q;
    logic   [CntW-1:0]              cnt_q;
    logic   [NSlices-1:0][BPC-1:0]  g_q;
    logic   [NSlices-1:0][BPC-1:0]  bin_q;
    // Last resolved binary bit; zero at the start models bin[WIDTH] = 0.
    logic                           carry_q;
    logic                           in_ready_q;
    logic                           out_valid_q;
    logic                           busy_q;

    logic   [BPC-1:0]               slice_g;
    logic   [BPC-1:0]               slice_b;
    logic                           slice_cout;

    assign slice_g = g_q[cnt_q];

    graydec_slice #(
        .BPC (BPC)
    ) u_slice (
        .cin  (carry_q),
        .g    (slice_g),
        .b    (slice_b),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            g_q         <= '0;
            bin_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (clear) begin
            // Operand and partial result are deliberately kept as-is.
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        state_q    <= StRun;
                        g_q        <= gray;
                        bin_q      <= '0;
                        carry_q    <= 1'b0;
                        cnt_q      <= CntW'(NSlices - 1);
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                StRun: begin
                    bin_q[cnt_q] <= slice_b;
                    carry_q      <= slice_cout;
                    if (cnt_q == '0) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign bin       = bin_q;

endmodule

// File: tb/tb_graydec_seq.sv
module tb_graydec_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] gray;
    logic        clear;
    logic        out_ready;

    logic        in_ready1, out_valid1, busy1;
    logic [31:0] bin1;
    logic        in_ready4, out_valid4, busy4;
    logic [31:0] bin4;

    int n_vec;
    int n_err;
    int hs_cnt;

    graydec_seq #(
        .WIDTH (32),
        .BPC   (1)
    ) dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .gray      (gray),
        .clear     (clear),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .bin       (bin1),
        .busy      (busy1)
    );

    graydec_seq #(
        .WIDTH (32),
        .BPC   (4)
    ) dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .gray      (gray),
        .clear     (clear),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .bin       (bin4),
        .busy      (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Results taken by the consumer on the BPC=1 instance.
    always @(posedge clk) begin
        if (reset && out_valid1 && out_ready && !clear) hs_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] g);
        gray     = g;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Returns the number of edges after the accept edge until out_valid1 is seen.
    task automatic wait_done1(output int lat);
        lat = 0;
        while (!out_valid1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic decode1(input string tag, input logic [31:0] g, input logic [31:0] exp);
        int lat;
        send(g);
        wait_done1(lat);
        check({tag, " latency"}, 32'(lat), 32'd32);
        check({tag, " bin"}, bin1, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " in_ready after"}, {31'd0, in_ready1}, 32'd1);
    endtask

    initial begin
        int          lat;
        int          h0;
        logic [31:0] held;
        logic [31:0] b;
        logic [31:0] g;
        bit          seen;
        bit          got1;
        bit          got4;

        n_vec     = 0;
        n_err     = 0;
        hs_cnt    = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        gray      = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        #23;
        check("rst in_ready", {31'd0, in_ready1}, 32'd1);
        check("rst out_valid", {31'd0, out_valid1}, 32'd0);
        check("rst busy", {31'd0, busy1}, 32'd0);
        check("rst bin", bin1, 32'd0);
        reset = 1'b1;
        tick();

        // Asynchronous reset in the middle of a run.
        send(32'h8000_0000);
        repeat (9) tick();
        check("midrun busy", {31'd0, busy1}, 32'd1);
        #3 reset = 1'b0;
        #1;
        check("async out_valid", {31'd0, out_valid1}, 32'd0);
        check("async busy", {31'd0, busy1}, 32'd0);
        check("async bin", bin1, 32'd0);
        #2 reset = 1'b1;
        tick();
        check("post rst in_ready", {31'd0, in_ready1}, 32'd1);

        // Directed decodes.
        decode1("g0000000f", 32'h0000_000F, 32'h0000_000A);
        decode1("g80000000", 32'h8000_0000, 32'hFFFF_FFFF);
        decode1("g00000003", 32'h0000_0003, 32'h0000_0002);
        decode1("gc0000001", 32'hC000_0001, 32'h8000_0001);

        // Back-pressure: result must hold while out_ready stays low.
        send(32'h0000_000F);
        wait_done1(lat);
        check("bp latency", 32'(lat), 32'd32);
        held = bin1;
        check("bp bin", held, 32'h0000_000A);
        for (int i = 0; i < 20; i++) begin
            gray     = 32'h1234_5678;
            in_valid = i[0];
            tick();
            check("bp hold bin", bin1, 32'h0000_000A);
            check("bp in_ready", {31'd0, in_ready1}, 32'd0);
            check("bp out_valid", {31'd0, out_valid1}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp release in_ready", {31'd0, in_ready1}, 32'd1);
        check("bp release out_valid", {31'd0, out_valid1}, 32'd0);

        // Abort during RUN.
        send(32'h8000_0000);
        repeat (4) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("abort in_ready", {31'd0, in_ready1}, 32'd1);
        check("abort busy", {31'd0, busy1}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid1) seen = 1'b1;
        end
        check("abort no out_valid", {31'd0, seen}, 32'd0);
        decode1("after abort", 32'h0000_000F, 32'h0000_000A);

        // clear beats out_ready in DONE.
        send(32'h0000_0003);
        wait_done1(lat);
        check("clr+rdy latency", 32'(lat), 32'd32);
        h0        = hs_cnt;
        clear     = 1'b1;
        out_ready = 1'b1;
        tick();
        clear     = 1'b0;
        out_ready = 1'b0;
        check("clr+rdy out_valid", {31'd0, out_valid1}, 32'd0);
        check("clr+rdy in_ready", {31'd0, in_ready1}, 32'd1);
        check("clr+rdy bin kept", bin1, 32'h0000_0002);
        check("clr+rdy no handshake", 32'(hs_cnt), 32'(h0));

        // Round trip through the ALU Gray-encode rule on both instances.
        out_ready = 1'b1;
        for (int v = 0; v < 1000; v++) begin
            b = $urandom;
            g = b ^ (b >> 1);
            send(g);
            got1 = 1'b0;
            got4 = 1'b0;
            for (int c = 1; c <= 40; c++) begin
                tick();
                if (out_valid4 && !got4) begin
                    got4 = 1'b1;
                    check("rt bpc4 latency", 32'(c), 32'd8);
                    check("rt bpc4 bin", bin4, b);
                end
                if (out_valid1 && !got1) begin
                    got1 = 1'b1;
                    check("rt bpc1 latency", 32'(c), 32'd32);
                    check("rt bpc1 bin", bin1, b);
                    break;
                end
            end
            if (!got1) check("rt bpc1 timeout", {31'd0, got1}, 32'd1);
            if (!got4) check("rt bpc4 timeout", {31'd0, got4}, 32'd1);
            tick();
        end
        out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
